// File: rtl/axi_arb2_pkg.sv
// Shared types and constants for the 2:1 AXI-lite arbiter.
// Master 0 is the instruction fetch unit and master 1 is the load/store unit.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } arb_state_t;

    localparam int unsigned M_IFU = 0;
    localparam int unsigned M_LSU = 1;

endpackage

// File: rtl/axi_arb2_if.sv
// Single-beat AXI-lite channel bundle without IDs or response codes.
// The master modport drives requests and the slave modport drives responses.
interface axi_arb2_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0]   AW_ADDR;
    logic                AW_VALID;
    logic                AW_READY;
    logic [DATA_W-1:0]   W_DATA;
    logic [DATA_W/8-1:0] W_STRB;
    logic                W_VALID;
    logic                W_READY;
    logic                B_VALID;
    logic                B_READY;
    logic [ADDR_W-1:0]   AR_ADDR;
    logic                AR_VALID;
    logic                AR_READY;
    logic [DATA_W-1:0]   R_DATA;
    logic                R_VALID;
    logic                R_READY;

    modport master (
        output AW_ADDR, AW_VALID, input AW_READY,
        output W_DATA, W_STRB, W_VALID, input W_READY,
        input  B_VALID, output B_READY,
        output AR_ADDR, AR_VALID, input AR_READY,
        input  R_DATA, R_VALID, output R_READY
    );

    modport slave (
        input  AW_ADDR, AW_VALID, output AW_READY,
        input  W_DATA, W_STRB, W_VALID, output W_READY,
        output B_VALID, input B_READY,
        input  AR_ADDR, AR_VALID, output AR_READY,
        output R_DATA, R_VALID, input R_READY
    );

endinterface

// File: rtl/axi_arb2_rr.sv
// Two-requester pick for read arbitration: round-robin or fixed master-1 priority.
// last_i set means master 0 took the previous tie, so master 1 gets this one.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       tie_o
);

    always_comb begin
        tie_o = &req_i;
        gnt_o = req_i;
        if (tie_o) begin
            if (RR_EN) begin
                gnt_o = last_i ? 2'b10 : 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/axi_arb2.sv
// 2:1 AXI-lite arbiter sharing one memory slave between the IFU (m0) and LSU (m1).
// One single-beat transaction in flight; channels are forwarded combinationally from grant.
module axi_arb2
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_arb2_if.slave  m0,
    axi_arb2_if.slave  m1,
    axi_arb2_if.master s,
    output logic [1:0] grant,
    output logic       busy
);

    arb_state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] rd_req, rd_gnt;
    logic       rd_tie;

    logic                owner;
    logic                own_aw_valid, own_w_valid, own_b_ready, own_ar_valid, own_r_ready;
    logic [ADDR_W-1:0]   own_aw_addr, own_ar_addr;
    logic [DATA_W-1:0]   own_w_data;
    logic [DATA_W/8-1:0] own_w_strb;

    logic st_rd_a, st_rd_d, st_wr_aw, st_wr_b;
    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign owner        = grant_q[M_LSU];
    assign own_aw_valid = owner ? m1.AW_VALID : m0.AW_VALID;
    assign own_aw_addr  = owner ? m1.AW_ADDR  : m0.AW_ADDR;
    assign own_w_valid  = owner ? m1.W_VALID  : m0.W_VALID;
    assign own_w_data   = owner ? m1.W_DATA   : m0.W_DATA;
    assign own_w_strb   = owner ? m1.W_STRB   : m0.W_STRB;
    assign own_b_ready  = owner ? m1.B_READY  : m0.B_READY;
    assign own_ar_valid = owner ? m1.AR_VALID : m0.AR_VALID;
    assign own_ar_addr  = owner ? m1.AR_ADDR  : m0.AR_ADDR;
    assign own_r_ready  = owner ? m1.R_READY  : m0.R_READY;

    assign st_rd_a  = (state_q == RD_A);
    assign st_rd_d  = (state_q == RD_D);
    assign st_wr_aw = (state_q == WR_AW);
    assign st_wr_b  = (state_q == WR_B);

    // A write channel that already handshook is masked on both sides until WR_B.
    assign s.AW_ADDR  = own_aw_addr;
    assign s.AW_VALID = st_wr_aw & own_aw_valid & ~aw_done_q;
    assign s.W_DATA   = own_w_data;
    assign s.W_STRB   = own_w_strb;
    assign s.W_VALID  = st_wr_aw & own_w_valid & ~w_done_q;
    assign s.B_READY  = st_wr_b & own_b_ready;
    assign s.AR_ADDR  = own_ar_addr;
    assign s.AR_VALID = st_rd_a & own_ar_valid;
    assign s.R_READY  = st_rd_d & own_r_ready;

    assign aw_rdy = st_wr_aw & ~aw_done_q & s.AW_READY;
    assign w_rdy  = st_wr_aw & ~w_done_q & s.W_READY;
    assign b_vld  = st_wr_b & s.B_VALID;
    assign ar_rdy = st_rd_a & s.AR_READY;
    assign r_vld  = st_rd_d & s.R_VALID;

    assign m0.AW_READY = aw_rdy & grant_q[M_IFU];
    assign m0.W_READY  = w_rdy & grant_q[M_IFU];
    assign m0.B_VALID  = b_vld & grant_q[M_IFU];
    assign m0.AR_READY = ar_rdy & grant_q[M_IFU];
    assign m0.R_VALID  = r_vld & grant_q[M_IFU];
    assign m0.R_DATA   = (r_vld & grant_q[M_IFU]) ? s.R_DATA : '0;

    assign m1.AW_READY = aw_rdy & grant_q[M_LSU];
    assign m1.W_READY  = w_rdy & grant_q[M_LSU];
    assign m1.B_VALID  = b_vld & grant_q[M_LSU];
    assign m1.AR_READY = ar_rdy & grant_q[M_LSU];
    assign m1.R_VALID  = r_vld & grant_q[M_LSU];
    assign m1.R_DATA   = (r_vld & grant_q[M_LSU]) ? s.R_DATA : '0;

    assign aw_hs = s.AW_VALID & s.AW_READY;
    assign w_hs  = s.W_VALID & s.W_READY;
    assign b_hs  = s.B_VALID & s.B_READY;
    assign ar_hs = s.AR_VALID & s.AR_READY;
    assign r_hs  = s.R_VALID & s.R_READY;

    assign rd_req = {m1.AR_VALID, m0.AR_VALID};

    rr_arb2 #(.RR_EN(RR_EN)) u_rr (
        .req_i  (rd_req),
        .last_i (last_q),
        .gnt_o  (rd_gnt),
        .tie_o  (rd_tie)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (m1.AW_VALID) begin
                    grant_d = 2'b10;
                    state_d = WR_AW;
                end else if (|rd_gnt) begin
                    // A read winner that also has a write pending issues the write first.
                    grant_d = rd_gnt;
                    state_d = (rd_gnt[M_IFU] && m0.AW_VALID) ? WR_AW : RD_A;
                    if (rd_tie) begin
                        last_d = rd_gnt[M_IFU];
                    end
                end else if (m0.AW_VALID) begin
                    grant_d = 2'b01;
                    state_d = WR_AW;
                end
            end
            RD_A: begin
                if (ar_hs) begin
                    state_d = RD_D;
                end
            end
            RD_D: begin
                if (r_hs) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            WR_AW: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule
